// File: rtl/bridge_pingpong_buffer.sv
// Ping-pong row buffer: a writer fills one bank row by row while the reader
// drains the other bank element by element, in row-major or column-major order.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for bank_full[rd_bank]; first element loads on exit
// ST_STREAM | output register holds an element of rd_bank; advance on accept
module bridge_pingpong_buffer #(
  parameter  int WIDTH         = 16,
  parameter  int TOTAL_INPUT_W = 4,
  parameter  int DEPTH         = 8,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int SLICE_WIDTH   = $clog2(TOTAL_INPUT_W)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [TOTAL_INPUT_W*WIDTH-1:0] in_data,
  input  logic                           rd_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_last,
  output logic [1:0]                     bank_full
);

  localparam logic [ADDR_WIDTH-1:0]  ROW_LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [SLICE_WIDTH-1:0] SLICE_LAST = SLICE_WIDTH'(TOTAL_INPUT_W - 1);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  logic [WIDTH-1:0]       r_mem [2][DEPTH][TOTAL_INPUT_W];
  logic                   r_wr_bank;
  logic [ADDR_WIDTH-1:0]  r_wr_row;
  logic [1:0]             r_bank_full;
  logic                   r_rd_bank;
  logic [ADDR_WIDTH-1:0]  r_row;
  logic [SLICE_WIDTH-1:0] r_slice;
  logic                   r_mode;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [WIDTH-1:0]       r_out_data;
  state_t                 r_state;

  state_t                 w_state_nxt;
  logic                   w_wr_acc;
  logic                   w_load;
  logic                   w_release;
  logic [ADDR_WIDTH-1:0]  w_ld_row;
  logic [SLICE_WIDTH-1:0] w_ld_slice;
  logic                   w_ld_mode;
  logic [1:0]             w_set_vec;
  logic [1:0]             w_clr_vec;

  assign in_ready  = ~r_bank_full[r_wr_bank];
  assign w_wr_acc  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign bank_full = r_bank_full;

  // Row storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int k = 0; k < TOTAL_INPUT_W; k++) begin
        r_mem[r_wr_bank][r_wr_row][k] <= in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Write pointer: advance row per accepted beat, hop to other bank after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= '0;
    end else if (w_wr_acc) begin
      if (r_wr_row == ROW_LAST) begin
        r_wr_row  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_row <= r_wr_row + ADDR_WIDTH'(1);
      end
    end
  end

  // Full-flag set (writer) and clear (reader) always target different banks.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_wr_acc && (r_wr_row == ROW_LAST)) w_set_vec[r_wr_bank] = 1'b1;
    if (w_release)                          w_clr_vec[r_rd_bank] = 1'b1;
  end

  // Bank full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bank_full <= 2'b00;
    else        r_bank_full <= (r_bank_full | w_set_vec) & ~w_clr_vec;
  end

  // Reader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Reader next state and the coordinates of the element to load next.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_ld_row    = r_row;
    w_ld_slice  = r_slice;
    w_ld_mode   = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (r_bank_full[r_rd_bank]) begin
          w_load      = 1'b1;
          w_ld_row    = '0;
          w_ld_slice  = '0;
          w_ld_mode   = rd_mode;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!r_out_valid || out_ready) begin
          if (r_out_last) begin
            w_release   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_load = 1'b1;
            if (!r_mode) begin
              if (r_slice == SLICE_LAST) begin
                w_ld_slice = '0;
                w_ld_row   = r_row + ADDR_WIDTH'(1);
              end else begin
                w_ld_slice = r_slice + SLICE_WIDTH'(1);
              end
            end else begin
              if (r_row == ROW_LAST) begin
                w_ld_row   = '0;
                w_ld_slice = r_slice + SLICE_WIDTH'(1);
              end else begin
                w_ld_row = r_row + ADDR_WIDTH'(1);
              end
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reader datapath: output register, drain counters and bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank   <= 1'b0;
      r_row       <= '0;
      r_slice     <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_row       <= w_ld_row;
      r_slice     <= w_ld_slice;
      r_mode      <= w_ld_mode;
      r_out_data  <= r_mem[r_rd_bank][w_ld_row][w_ld_slice];
      r_out_valid <= 1'b1;
      r_out_last  <= (w_ld_row == ROW_LAST) && (w_ld_slice == SLICE_LAST);
    end else if (w_release) begin
      r_rd_bank   <= ~r_rd_bank;
      r_row       <= '0;
      r_slice     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bridge_pingpong_buffer.sv
// Bench for bridge_pingpong_buffer with a small 2x2 geometry; expected drain
// order comes from a queue-based model of the written rows.
module tb_bridge_pingpong_buffer;

  localparam int W   = 16;
  localparam int TIW = 2;
  localparam int D   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [TIW*W-1:0] in_data;
  logic             rd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [1:0]       bank_full;

  int n_pass  = 0;
  int n_total = 0;

  logic [TIW*W-1:0] wr_log[$];
  logic [W-1:0]     exp_data[$];
  bit               exp_last[$];
  logic [W-1:0]     got_data[$];
  bit               got_last[$];
  int               stall_err;
  bit               drain_to;

  bridge_pingpong_buffer #(.WIDTH(W), .TOTAL_INPUT_W(TIW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_mode(rd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one beat and wait (bounded) until it is taken.
  task automatic write_beat(input logic [TIW*W-1:0] d);
    int cyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    if (in_ready !== 1'b1) begin
      n_total++;
      $display("FAIL write_timeout: in_ready=%b required 1", in_ready);
    end else begin
      wr_log.push_back(d);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Collect n accepted elements; counts stalled elements that changed.
  task automatic drain(input int n, input bit rnd);
    int cyc = 0;
    bit pstall = 0;
    logic [W-1:0] pd = '0;
    got_data.delete(); got_last.delete();
    stall_err = 0; drain_to = 0;
    while (got_data.size() < n && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pstall && (out_valid !== 1'b1 || out_data !== pd)) stall_err++;
      if (out_valid === 1'b1 && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        pstall = 0;
      end else begin
        pstall = (out_valid === 1'b1);
        pd     = out_data;
      end
      tick(); cyc++;
    end
    if (got_data.size() < n) drain_to = 1;
    out_ready = 1'b0;
  endtask

  // Reference: each complete group of D rows is one bank, read in mode order.
  function automatic void build_expected(input bit mode);
    logic [TIW*W-1:0] row;
    int r, s;
    exp_data.delete(); exp_last.delete();
    for (int b = 0; b < wr_log.size() / D; b++) begin
      for (int k = 0; k < D*TIW; k++) begin
        if (!mode) begin r = k / TIW; s = k % TIW; end
        else       begin r = k % D;   s = k / D;   end
        row = wr_log[b*D + r];
        exp_data.push_back(row[s*W +: W]);
        exp_last.push_back(k == D*TIW - 1);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rd_mode = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    n_total++; if (in_ready !== 1'b1)      $display("FAIL reset_in_ready: got %b required 1", in_ready);      else n_pass++;
    n_total++; if (out_valid !== 1'b0)     $display("FAIL reset_out_valid: got %b required 0", out_valid);    else n_pass++;
    n_total++; if (out_last !== 1'b0)      $display("FAIL reset_out_last: got %b required 0", out_last);      else n_pass++;
    n_total++; if (out_data !== 16'h0)     $display("FAIL reset_out_data: got %h required 0000", out_data);   else n_pass++;
    n_total++; if (bank_full !== 2'b00)    $display("FAIL reset_bank_full: got %b required 00", bank_full);   else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_row_major();
    wr_log.delete(); rd_mode = 1'b0;
    write_beat({16'h0002, 16'h0001});
    write_beat({16'h0004, 16'h0003});
    n_total++; if (bank_full !== 2'b01) $display("FAIL latency_bank_full: got %b required 01", bank_full); else n_pass++;
    n_total++; if (out_valid !== 1'b0)  $display("FAIL latency_early_valid: got %b required 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h0001)
      $display("FAIL latency_first: valid=%b data=%h required 1/0001", out_valid, out_data); else n_pass++;
    drain(4, 0);
    build_expected(1'b0);
    n_total++; if (drain_to) $display("FAIL row_timeout: got %0d elements required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_total++;
      if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
      else $display("FAIL row_elem%0d: got %h/%b required %h/%b", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, (i < got_last.size()) ? got_last[i] : 1'b0,
                    exp_data[i], exp_last[i]);
    end
    n_total++; if (bank_full !== 2'b00) $display("FAIL row_bank_free: got %b required 00", bank_full); else n_pass++;
  endtask

  task automatic test_col_major();
    wr_log.delete(); rd_mode = 1'b1;
    write_beat({16'h0002, 16'h0001});
    write_beat({16'h0004, 16'h0003});
    drain(4, 0);
    build_expected(1'b1);
    n_total++; if (drain_to) $display("FAIL col_timeout: got %0d elements required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_total++;
      if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
      else $display("FAIL col_elem%0d: got %h required %h/%b", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i], exp_last[i]);
    end
    n_total++; if (got_data.size() > 1 && got_data[1] !== 16'h0003)
      $display("FAIL col_second: got %h required 0003", got_data[1]); else n_pass++;
  endtask

  task automatic test_random_stall();
    bit mode;
    for (int rep = 0; rep < 3; rep++) begin
      wr_log.delete();
      mode = 1'($urandom_range(0, 1)); rd_mode = mode;
      for (int b = 0; b < D; b++) write_beat(TIW*W'($urandom));
      drain(D*TIW, 1);
      build_expected(mode);
      n_total++; if (drain_to || stall_err != 0)
        $display("FAIL stall_rep%0d: timeout=%0d unstable=%0d required 0/0", rep, drain_to, stall_err); else n_pass++;
      for (int i = 0; i < exp_data.size(); i++) begin
        n_total++;
        if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
        else $display("FAIL stall_rep%0d_elem%0d: got %h required %h", rep, i,
                      (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i]);
      end
    end
  endtask

  task automatic test_both_full();
    wr_log.delete(); rd_mode = 1'b0; out_ready = 1'b0;
    for (int b = 0; b < 2*D; b++) write_beat(TIW*W'($urandom));
    n_total++; if (bank_full !== 2'b11) $display("FAIL full_flags: got %b required 11", bank_full); else n_pass++;
    n_total++; if (in_ready !== 1'b0)   $display("FAIL full_in_ready: got %b required 0", in_ready); else n_pass++;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    in_valid = 1'b0;
    n_total++; if (bank_full !== 2'b11 || in_ready !== 1'b0)
      $display("FAIL full_ignore: flags=%b in_ready=%b required 11/0", bank_full, in_ready); else n_pass++;
    drain(2*D*TIW, 0);
    build_expected(1'b0);
    n_total++; if (drain_to) $display("FAIL full_timeout: got %0d elements required 8", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_total++;
      if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
      else $display("FAIL full_elem%0d: got %h required %h/%b", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i], exp_last[i]);
    end
    n_total++; if (bank_full !== 2'b00 || in_ready !== 1'b1)
      $display("FAIL full_released: flags=%b in_ready=%b required 00/1", bank_full, in_ready); else n_pass++;
  endtask

  task automatic test_concurrent();
    logic [1:0] bf_hist[$];
    bit         rdy_hist[$];
    int         hit = -1;
    wr_log.delete(); rd_mode = 1'b0;
    fork
      begin
        write_beat(TIW*W'($urandom));
        write_beat(TIW*W'($urandom));
        repeat (3) tick();
        write_beat(TIW*W'($urandom));
        write_beat(TIW*W'($urandom));
      end
      drain(2*D*TIW, 0);
      begin
        repeat (24) begin tick(); bf_hist.push_back(bank_full); rdy_hist.push_back(in_ready); end
      end
    join
    for (int i = 0; i + 1 < bf_hist.size(); i++)
      if (hit < 0 && (bf_hist[i] == 2'b01 || bf_hist[i] == 2'b10) && bf_hist[i+1] == ~bf_hist[i]) hit = i;
    n_total++; if (hit < 0) $display("FAIL conc_swap: no cycle with set and clear together, got none required one"); else n_pass++;
    n_total++; if (hit >= 0 && rdy_hist[hit+1] !== 1'b1)
      $display("FAIL conc_freed_ready: got %b required 1", rdy_hist[hit+1]); else n_pass++;
    build_expected(1'b0);
    n_total++; if (drain_to) $display("FAIL conc_timeout: got %0d elements required 8", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_total++;
      if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
      else $display("FAIL conc_elem%0d: got %h required %h", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i]);
    end
  endtask

  task automatic test_reset_mid_stream();
    wr_log.delete(); rd_mode = 1'b0;
    write_beat({16'h0002, 16'h0001});
    write_beat({16'h0004, 16'h0003});
    drain(1, 0);
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0)
      $display("FAIL midrst_out: valid=%b last=%b data=%h required 0/0/0000", out_valid, out_last, out_data); else n_pass++;
    n_total++; if (bank_full !== 2'b00 || in_ready !== 1'b1)
      $display("FAIL midrst_flags: flags=%b in_ready=%b required 00/1", bank_full, in_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    wr_log.delete();
    write_beat({16'h0002, 16'h0001});
    write_beat({16'h0004, 16'h0003});
    drain(4, 0);
    build_expected(1'b0);
    n_total++; if (got_data.size() < 1 || got_data[0] !== 16'h0001)
      $display("FAIL midrst_first: got %h required 0001", (got_data.size() > 0) ? got_data[0] : 16'hxxxx); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_total++;
      if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
      else $display("FAIL midrst_elem%0d: got %h required %h", i,
                    (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i]);
    end
  endtask

  task automatic test_back_to_back();
    bit mode;
    for (int rep = 0; rep < 2; rep++) begin
      wr_log.delete();
      mode = 1'(rep); rd_mode = mode;
      fork
        begin
          for (int b = 0; b < 4*D; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            write_beat(TIW*W'($urandom));
          end
        end
        drain(4*D*TIW, 1);
      join
      build_expected(mode);
      n_total++; if (drain_to || stall_err != 0)
        $display("FAIL b2b_rep%0d: timeout=%0d unstable=%0d required 0/0", rep, drain_to, stall_err); else n_pass++;
      for (int i = 0; i < exp_data.size(); i++) begin
        n_total++;
        if (i < got_data.size() && got_data[i] === exp_data[i] && got_last[i] === exp_last[i]) n_pass++;
        else $display("FAIL b2b_rep%0d_elem%0d: got %h required %h/%b", rep, i,
                      (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp_data[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_random_stall();
    test_both_full();
    test_concurrent();
    test_reset_mid_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bridge_pingpong_buffer.md
BRIDGE_PINGPONG_BUFFER -- requirements
Module: bridge_pingpong_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of one element.
REQ-002 SHALL have parameter TOTAL_INPUT_W, default 4, elements per write beat (slices per row, >=2).
REQ-003 SHALL have parameter DEPTH, default 8, rows per bank (>=2); ADDR_WIDTH = $clog2(DEPTH) is derived.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  write beat offered.
REQ-007 SHALL have port in_ready  output  1  write beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  TOTAL_INPUT_W*WIDTH  one row; slice k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port rd_mode  input  1  0 = row-major drain (west order), 1 = column-major drain (north order).
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-011 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  WIDTH  drained element.
REQ-013 SHALL have port out_last  output  1  high with the final element of a bank.
REQ-014 SHALL have port bank_full  output  2  per-bank full flags.

Function
REQ-015 SHALL hold two banks (0,1), each DEPTH rows x TOTAL_INPUT_W elements, register-based storage.
REQ-016 SHALL keep write pointer wr_bank and row counter wr_row; in_ready = ~bank_full[wr_bank] (combinational from registers).
REQ-017 SHALL on each accepted beat store in_data into row wr_row of wr_bank and increment wr_row.
REQ-018 SHALL on the accepted beat with wr_row = DEPTH-1 set bank_full[wr_bank], reset wr_row to 0 and toggle wr_bank on the same edge.
REQ-019 SHALL implement reader FSM with states IDLE and STREAM, plus rd_bank pointer, row counter r and slice counter s.
REQ-020 SHALL in IDLE with bank_full[rd_bank]=1 latch rd_mode, move to STREAM and load element (r=0,s=0) into the output register on the same edge (out_valid high the following cycle).
REQ-021 SHALL load the next element only when out_valid=0 or out_ready=1; otherwise out_data/out_valid/out_last hold stable.
REQ-022 SHALL in row-major mode advance s fastest (s wraps TOTAL_INPUT_W-1 -> 0, then r++); in column-major mode advance r fastest (r wraps DEPTH-1 -> 0, then s++).
REQ-023 SHALL assert out_last with element (r=DEPTH-1, s=TOTAL_INPUT_W-1) for either mode.
REQ-024 SHALL when the element with out_last is accepted clear bank_full[rd_bank], toggle rd_bank, and return to IDLE; if no new element loads, out_valid drops next cycle.
REQ-025 SHALL ignore rd_mode changes while in STREAM.
REQ-026 SHALL allow a set of bank_full on one bank and a clear on the other bank in the same cycle; both take effect.
REQ-027 SHALL freed bank become writable (in_ready high) the cycle after its bank_full clears.
REQ-028 SHALL ignore in_valid while in_ready=0 (no store, no counter change).
REQ-029 SHALL with both banks full hold in_ready=0 until the reader releases a bank.
REQ-030 SHALL have minimum latency: last write beat at edge T -> first out_valid at T+2.

Reset
REQ-031 SHALL on rst_n=0 asynchronously force: FSM=IDLE, wr_bank=rd_bank=0, wr_row=r=s=0, bank_full=2'b00, out_valid=0, out_last=0, out_data=0; in_ready=1.
REQ-032 SHALL discard partially written or partially drained banks on reset; storage contents need not be cleared.

Verification (WIDTH=16, TOTAL_INPUT_W=2, DEPTH=2; beats row0 slices {0x0001,0x0002}, row1 {0x0003,0x0004})
REQ-033 SHALL verify rd_mode=0, out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004, out_last only on 0x0004, bank_full 01->00.
REQ-034 SHALL verify rd_mode=1 -> out_data 0x0001,0x0003,0x0002,0x0004, out_last on 0x0004.
REQ-035 SHALL verify out_ready toggled randomly -> same sequence, no drop or duplicate, out_data stable while stalled.
REQ-036 SHALL verify four beats with out_ready=0 -> bank_full=11, in_ready=0, fifth beat ignored; raise out_ready -> bank 0 then bank 1 drained in order.
REQ-037 SHALL verify concurrent fill of bank 1 while bank 0 drains, incl. cycle where bank_full[1] sets and bank_full[0] clears -> both flags correct.
REQ-038 SHALL verify rst_n asserted mid-STREAM after 1 element -> outputs at reset values immediately; refill yields 0x0001 first.
